// File: rtl/avalon_tx_arbiter_if.sv
// AXIS beat bundle shared by the three TLP sources and the merged TX stream.
// tdest is only meaningful on the merged side and tells which source a beat came from.
interface avalon_tx_arbiter_if #(
   parameter int DATA_W = 128,
   parameter int STRB_W = DATA_W / 8,
   parameter int USER_W = 4
);
   logic [DATA_W-1:0] tdata;
   logic [STRB_W-1:0] tstrb;
   logic              tlast;
   logic [USER_W-1:0] tuser;
   logic [1:0]        tdest;
   logic              tvalid;
   logic              tready;

   modport master (
      output tdata, tstrb, tlast, tuser, tdest, tvalid,
      input  tready
   );

   modport slave (
      input  tdata, tstrb, tlast, tuser, tvalid,
      output tready
   );
endinterface

// File: rtl/avalon_tx_arbiter.sv
// Packet-level arbiter sharing one registered AXIS TX path between the rw, rr and cc
// TLP sources; a granted source owns the path from its first beat through tlast.
module avalon_tx_arbiter #(
   parameter int AXI_DATA_WIDTH = 128,
   parameter int BE_WIDTH       = AXI_DATA_WIDTH / 8,
   parameter int USER_WIDTH_TX  = 4,
   parameter int CC_PRIORITY    = 1
) (
   input  logic                axi_clk,
   input  logic                axi_rst,
   avalon_tx_arbiter_if.slave  s_axis_rw,
   avalon_tx_arbiter_if.slave  s_axis_rr,
   avalon_tx_arbiter_if.slave  s_axis_cc,
   avalon_tx_arbiter_if.master m_axis_tx,
   output logic [2:0]          arb_grant,
   output logic                arb_busy
);
   typedef enum logic {IDLE, LOCK} state_t;

   // With cc priority only rw/rr rotate, so one bit is enough to remember the last of them.
   localparam int RR_W = (CC_PRIORITY != 0) ? 1 : 2;
   localparam logic [RR_W-1:0] RR_RESET = (CC_PRIORITY != 0) ? RR_W'(1) : RR_W'(2);

   state_t                    state_reg;
   logic [2:0]                grant_reg;
   logic [1:0]                grant_idx_reg;
   logic                      busy_reg;
   logic [RR_W-1:0]           rr_last_reg;

   logic [AXI_DATA_WIDTH-1:0] tx_data_reg;
   logic [BE_WIDTH-1:0]       tx_strb_reg;
   logic                      tx_last_reg;
   logic [USER_WIDTH_TX-1:0]  tx_user_reg;
   logic [1:0]                tx_dest_reg;
   logic                      tx_valid_reg;

   logic [2:0]                valid_vec;
   logic                      out_free;
   logic                      src_accept;
   logic [1:0]                pick_idx;
   logic                      rr_upd;
   logic [RR_W-1:0]           rr_last_next;

   logic [AXI_DATA_WIDTH-1:0] sel_data;
   logic [BE_WIDTH-1:0]       sel_strb;
   logic                      sel_last;
   logic [USER_WIDTH_TX-1:0]  sel_user;

   assign valid_vec  = {s_axis_cc.tvalid, s_axis_rr.tvalid, s_axis_rw.tvalid};
   assign out_free   = ~tx_valid_reg | m_axis_tx.tready;
   assign src_accept = (|(grant_reg & valid_vec)) & out_free;

   assign s_axis_rw.tready = grant_reg[0] & out_free;
   assign s_axis_rr.tready = grant_reg[1] & out_free;
   assign s_axis_cc.tready = grant_reg[2] & out_free;

   always_comb begin
      sel_data = s_axis_rw.tdata;
      sel_strb = s_axis_rw.tstrb;
      sel_last = s_axis_rw.tlast;
      sel_user = s_axis_rw.tuser;
      case (grant_idx_reg)
         2'd1: begin
            sel_data = s_axis_rr.tdata;
            sel_strb = s_axis_rr.tstrb;
            sel_last = s_axis_rr.tlast;
            sel_user = s_axis_rr.tuser;
         end
         2'd2: begin
            sel_data = s_axis_cc.tdata;
            sel_strb = s_axis_cc.tstrb;
            sel_last = s_axis_cc.tlast;
            sel_user = s_axis_cc.tuser;
         end
         default: ;
      endcase
   end

   generate
      if (CC_PRIORITY != 0) begin : g_cc_prio
         // cc wins outright; rw takes the turn when rr went last or rr is not asking.
         always_comb begin
            pick_idx = 2'd0;
            rr_upd   = 1'b0;
            if (valid_vec[2]) begin
               pick_idx = 2'd2;
            end else if (valid_vec[0] && (rr_last_reg[0] || !valid_vec[1])) begin
               pick_idx = 2'd0;
               rr_upd   = 1'b1;
            end else if (valid_vec[1]) begin
               pick_idx = 2'd1;
               rr_upd   = 1'b1;
            end
         end
      end else begin : g_round_robin
         logic [1:0] ord0, ord1, ord2;
         always_comb begin
            case (rr_last_reg)
               2'd0:    begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
               2'd1:    begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
               default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
            endcase
            if (valid_vec[ord0])      pick_idx = ord0;
            else if (valid_vec[ord1]) pick_idx = ord1;
            else                      pick_idx = ord2;
         end
         assign rr_upd = 1'b1;
      end
   endgenerate

   assign rr_last_next = pick_idx[RR_W-1:0];

   always_ff @(posedge axi_clk or negedge axi_rst) begin
      if (!axi_rst) begin
         state_reg     <= IDLE;
         grant_reg     <= 3'b000;
         grant_idx_reg <= 2'd0;
         busy_reg      <= 1'b0;
         rr_last_reg   <= RR_RESET;
      end else begin
         case (state_reg)
            IDLE: begin
               if (|valid_vec) begin
                  state_reg     <= LOCK;
                  grant_reg     <= 3'b001 << pick_idx;
                  grant_idx_reg <= pick_idx;
                  busy_reg      <= 1'b1;
                  if (rr_upd) rr_last_reg <= rr_last_next;
               end
            end
            LOCK: begin
               // Gaps in the granted source's tvalid simply stall here; only tlast releases.
               if (src_accept && sel_last) begin
                  state_reg <= IDLE;
                  grant_reg <= 3'b000;
                  busy_reg  <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge axi_clk or negedge axi_rst) begin
      if (!axi_rst) begin
         tx_data_reg  <= '0;
         tx_strb_reg  <= '0;
         tx_last_reg  <= 1'b0;
         tx_user_reg  <= '0;
         tx_dest_reg  <= 2'd0;
         tx_valid_reg <= 1'b0;
      end else if (src_accept) begin
         tx_data_reg  <= sel_data;
         tx_strb_reg  <= sel_strb;
         tx_last_reg  <= sel_last;
         tx_user_reg  <= sel_user;
         tx_dest_reg  <= grant_idx_reg;
         tx_valid_reg <= 1'b1;
      end else if (m_axis_tx.tready) begin
         tx_valid_reg <= 1'b0;
      end
   end

   assign m_axis_tx.tdata  = tx_data_reg;
   assign m_axis_tx.tstrb  = tx_strb_reg;
   assign m_axis_tx.tlast  = tx_last_reg;
   assign m_axis_tx.tuser  = tx_user_reg;
   assign m_axis_tx.tdest  = tx_dest_reg;
   assign m_axis_tx.tvalid = tx_valid_reg;

   assign arb_grant = grant_reg;
   assign arb_busy  = busy_reg;
endmodule

// File: tb/tb_avalon_tx_arbiter.sv
// Bench for avalon_tx_arbiter: a cc-priority instance (d0) and a pure round-robin instance (d1)
// run side by side against a cycle-level behavioural model of the arbitration rules.
`timescale 1ns/1ps
module tb_avalon_tx_arbiter;
   localparam int DW = 128;
   localparam int BW = 16;
   localparam int UW = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [BW-1:0] strb;
      logic          last;
      logic [UW-1:0] user;
   } beat_t;

   logic axi_clk = 1'b0;
   logic axi_rst = 1'b0;
   always #5 axi_clk = ~axi_clk;

   logic [DW-1:0]   s_data [6];
   logic [BW-1:0]   s_strb [6];
   logic [UW-1:0]   s_user [6];
   logic [5:0]      s_last, s_valid, s_ready;
   logic [1:0]      m_ready, m_valid, m_last, busy;
   logic [2*DW-1:0] m_data_all;
   logic [2*BW-1:0] m_strb_all;
   logic [2*UW-1:0] m_user_all;
   logic [3:0]      m_dest_all;
   logic [5:0]      grant_all;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      avalon_tx_arbiter_if #(.DATA_W(DW), .STRB_W(BW), .USER_W(UW)) src_if [3] ();
      avalon_tx_arbiter_if #(.DATA_W(DW), .STRB_W(BW), .USER_W(UW)) tx_if ();
      for (genvar gj = 0; gj < 3; gj++) begin : g_src
         assign src_if[gj].tdata  = s_data[gi*3+gj];
         assign src_if[gj].tstrb  = s_strb[gi*3+gj];
         assign src_if[gj].tlast  = s_last[gi*3+gj];
         assign src_if[gj].tuser  = s_user[gi*3+gj];
         assign src_if[gj].tvalid = s_valid[gi*3+gj];
         assign src_if[gj].tdest  = 2'd0;
         assign s_ready[gi*3+gj]  = src_if[gj].tready;
      end
      assign tx_if.tready             = m_ready[gi];
      assign m_valid[gi]              = tx_if.tvalid;
      assign m_last[gi]               = tx_if.tlast;
      assign m_data_all[gi*DW +: DW]  = tx_if.tdata;
      assign m_strb_all[gi*BW +: BW]  = tx_if.tstrb;
      assign m_user_all[gi*UW +: UW]  = tx_if.tuser;
      assign m_dest_all[gi*2 +: 2]    = tx_if.tdest;

      avalon_tx_arbiter #(
         .AXI_DATA_WIDTH(DW), .BE_WIDTH(BW), .USER_WIDTH_TX(UW),
         .CC_PRIORITY(gi == 0 ? 1 : 0)
      ) u_dut (
         .axi_clk   (axi_clk),
         .axi_rst   (axi_rst),
         .s_axis_rw (src_if[0]),
         .s_axis_rr (src_if[1]),
         .s_axis_cc (src_if[2]),
         .m_axis_tx (tx_if),
         .arb_grant (grant_all[gi*3 +: 3]),
         .arb_busy  (busy[gi])
      );
   end

   // Source queues and the behavioural model.
   beat_t pend [6][$];
   bit    pres [6];
   int    owner [2];
   int    rrp [2];
   bit    mo_valid [2];
   beat_t mo_beat [2];
   int    mo_dest [2];
   int    gap_pct, bp_pct;
   bit    refill;
   int    errors = 0;
   int    checks = 0;
   int    got0 [$];
   int    got1 [$];
   int    last_cyc [2];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // First requester in the policy order; -1 when nobody asks.
   function automatic int pick(input int d, input logic [2:0] v);
      int res;
      int c;
      res = -1;
      if (d == 0 && v[2]) res = 2;
      else if (d == 0) begin
         for (int k = 1; k <= 2; k++) begin
            c = (rrp[d] + k) % 2;
            if (res < 0 && v[c]) res = c;
         end
      end else begin
         for (int k = 1; k <= 3; k++) begin
            c = (rrp[d] + k) % 3;
            if (res < 0 && v[c]) res = c;
         end
      end
      return res;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         owner[d]    = -1;
         rrp[d]      = (d == 0) ? 1 : 2;
         mo_valid[d] = 1'b0;
         mo_beat[d]  = '0;
         mo_dest[d]  = 0;
      end
      for (int i = 0; i < 6; i++) begin
         pend[i].delete();
         pres[i]    = 1'b0;
         s_valid[i] = 1'b0;
         s_last[i]  = 1'b0;
         s_data[i]  = '0;
         s_strb[i]  = '0;
         s_user[i]  = '0;
      end
      m_ready = 2'b11;
   endtask

   task automatic add_pkt(input int i, input int len, input bit rnd, input int base);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data = rnd ? {$urandom, $urandom, $urandom, $urandom} : DW'(base + k + 1);
         b.strb = rnd ? BW'($urandom) : '1;
         b.user = rnd ? UW'($urandom) : UW'(i);
         b.last = (k == len - 1);
         pend[i].push_back(b);
      end
   endtask

   task automatic drive();
      beat_t b;
      for (int i = 0; i < 6; i++) begin
         if (refill && pend[i].size() == 0) add_pkt(i, int'($urandom_range(1, 4)), 1'b1, 0);
         if (!pres[i] && pend[i].size() != 0 && int'($urandom_range(0, 99)) >= gap_pct) pres[i] = 1'b1;
         s_valid[i] = pres[i];
         if (pres[i]) begin
            b = pend[i][0];
            s_data[i] = b.data;
            s_strb[i] = b.strb;
            s_last[i] = b.last;
            s_user[i] = b.user;
         end else begin
            s_data[i] = {$urandom, $urandom, $urandom, $urandom};
            s_strb[i] = BW'($urandom);
            s_last[i] = 1'($urandom_range(0, 1));
            s_user[i] = UW'($urandom);
         end
      end
      for (int d = 0; d < 2; d++) m_ready[d] = (int'($urandom_range(0, 99)) >= bp_pct);
   endtask

   task automatic check_step();
      for (int d = 0; d < 2; d++) begin
         logic [2:0] vv, er, ar, eg;
         int         p, idx;
         bit         fire;
         beat_t      b;
         string      t;
         t = $sformatf("d%0d", d);
         for (int s = 0; s < 3; s++) begin
            vv[s] = s_valid[d*3+s];
            er[s] = (owner[d] == s) && (!mo_valid[d] || m_ready[d]);
            ar[s] = s_ready[d*3+s];
         end
         eg = (owner[d] >= 0) ? 3'(1 << owner[d]) : 3'b000;
         chk({t, " tready"},    DW'(ar), DW'(er));
         chk({t, " arb_grant"}, DW'(grant_all[d*3 +: 3]), DW'(eg));
         chk({t, " arb_busy"},  DW'(busy[d]), DW'(owner[d] >= 0));
         chk({t, " tx_tvalid"}, DW'(m_valid[d]), DW'(mo_valid[d]));
         if (mo_valid[d]) begin
            chk({t, " tx_tdata"}, m_data_all[d*DW +: DW], mo_beat[d].data);
            chk({t, " tx_tstrb"}, DW'(m_strb_all[d*BW +: BW]), DW'(mo_beat[d].strb));
            chk({t, " tx_tlast"}, DW'(m_last[d]), DW'(mo_beat[d].last));
            chk({t, " tx_tuser"}, DW'(m_user_all[d*UW +: UW]), DW'(mo_beat[d].user));
            chk({t, " tx_tdest"}, DW'(m_dest_all[d*2 +: 2]), DW'(mo_dest[d]));
         end
         fire = 1'b0;
         if (owner[d] >= 0) fire = er[owner[d]] && vv[owner[d]];
         if (fire) begin
            idx         = d*3 + owner[d];
            b           = pend[idx].pop_front();
            pres[idx]   = 1'b0;
            mo_beat[d]  = b;
            mo_valid[d] = 1'b1;
            mo_dest[d]  = owner[d];
            if (b.last) owner[d] = -1;
         end else begin
            if (m_ready[d]) mo_valid[d] = 1'b0;
            if (owner[d] < 0) begin
               p = pick(d, vv);
               if (p >= 0) begin
                  owner[d] = p;
                  if (d == 1 || p != 2) rrp[d] = p;
               end
            end
         end
      end
   endtask

   task automatic run_cycle();
      drive();
      #1;
      check_step();
      @(posedge axi_clk);
      #1;
   endtask

   task automatic check_zero(input string name);
      for (int d = 0; d < 2; d++) begin
         string t;
         t = $sformatf("%s d%0d", name, d);
         chk({t, " arb_grant"}, DW'(grant_all[d*3 +: 3]), '0);
         chk({t, " arb_busy"},  DW'(busy[d]), '0);
         chk({t, " tx_tvalid"}, DW'(m_valid[d]), '0);
         chk({t, " tx_tdata"},  m_data_all[d*DW +: DW], '0);
         chk({t, " tx_tstrb"},  DW'(m_strb_all[d*BW +: BW]), '0);
         chk({t, " tx_tlast"},  DW'(m_last[d]), '0);
         chk({t, " tx_tuser"},  DW'(m_user_all[d*UW +: UW]), '0);
         chk({t, " tx_tdest"},  DW'(m_dest_all[d*2 +: 2]), '0);
         chk({t, " tready"},    DW'(s_ready[d*3 +: 3]), '0);
      end
   endtask

   task automatic release_reset();
      model_reset();
      @(posedge axi_clk);
      #1;
      axi_rst = 1'b1;
   endtask

   initial begin
      int exp0 [3];
      int exp1 [6];
      exp0 = '{2, 0, 1};
      exp1 = '{0, 1, 2, 0, 1, 2};
      gap_pct = 0;
      bp_pct  = 0;
      refill  = 1'b0;
      model_reset();
      axi_rst = 1'b0;
      repeat (3) @(posedge axi_clk);
      #1;
      check_zero("reset");
      axi_rst = 1'b1;

      // All sources request at once: 2-beat TLPs on d0, two 1-beat TLPs each on d1.
      for (int s = 0; s < 3; s++) begin
         add_pkt(s, 2, 1'b0, 16 * s);
         add_pkt(3 + s, 1, 1'b0, 16 * s);
         add_pkt(3 + s, 1, 1'b0, 16 * s + 8);
      end
      for (int c = 0; c < 16; c++) begin
         if (c == 1) begin
            chk("d0 first grant", DW'(grant_all[2:0]), DW'(3'b100));
            chk("d1 first grant", DW'(grant_all[5:3]), DW'(3'b001));
         end
         if (c == 2) begin
            chk("first beat valid", DW'(m_valid), DW'(2'b11));
            chk("d0 first tdest", DW'(m_dest_all[1:0]), DW'(2));
            chk("d1 first tdest", DW'(m_dest_all[3:2]), DW'(0));
         end
         if (m_valid[0] && m_last[0]) begin got0.push_back(int'(m_dest_all[1:0])); last_cyc[0] = c; end
         if (m_valid[1] && m_last[1]) begin got1.push_back(int'(m_dest_all[3:2])); last_cyc[1] = c; end
         run_cycle();
      end
      chk("d0 packet count", DW'(got0.size()), DW'(3));
      chk("d1 packet count", DW'(got1.size()), DW'(6));
      for (int k = 0; k < 3; k++) if (k < got0.size()) chk($sformatf("d0 packet order %0d", k), DW'(got0[k]), DW'(exp0[k]));
      for (int k = 0; k < 6; k++) if (k < got1.size()) chk($sformatf("d1 packet order %0d", k), DW'(got1[k]), DW'(exp1[k]));
      chk("d0 last tlast cycle", DW'(last_cyc[0]), DW'(9));
      chk("d1 last tlast cycle", DW'(last_cyc[1]), DW'(12));

      // Random traffic with source gaps and downstream backpressure.
      refill  = 1'b1;
      gap_pct = 30;
      bp_pct  = 35;
      repeat (3000) run_cycle();

      refill  = 1'b0;
      gap_pct = 0;
      bp_pct  = 0;
      axi_rst = 1'b0;
      #1;
      check_zero("reset after random");
      release_reset();

      // Single rw 4-beat TLP, data 1..4.
      add_pkt(0, 4, 1'b0, 0);
      add_pkt(3, 4, 1'b0, 0);
      for (int c = 0; c < 8; c++) begin
         if (c >= 2 && c <= 5) begin
            for (int d = 0; d < 2; d++) begin
               chk($sformatf("d%0d 4beat data c%0d", d, c), m_data_all[d*DW +: DW], DW'(c - 1));
               chk($sformatf("d%0d 4beat tlast c%0d", d, c), DW'(m_last[d]), DW'(c == 5));
               chk($sformatf("d%0d 4beat tdest c%0d", d, c), DW'(m_dest_all[d*2 +: 2]), '0);
            end
         end
         if (c == 4) chk("busy before last accept", DW'(busy), DW'(2'b11));
         if (c == 5) chk("busy after last accept", DW'(busy), DW'(2'b00));
         run_cycle();
      end

      // Asynchronous reset while beat 2 of 4 is on the output.
      add_pkt(0, 4, 1'b0, 32);
      add_pkt(3, 4, 1'b0, 32);
      for (int c = 0; c < 3; c++) run_cycle();
      chk("d0 beat2 before reset", m_data_all[DW-1:0], DW'(34));
      chk("d1 beat2 before reset", m_data_all[2*DW-1:DW], DW'(34));
      #2;
      axi_rst = 1'b0;
      #1;
      check_zero("async reset");
      release_reset();

      // After reset rw must be granted first, ahead of a waiting rr.
      add_pkt(0, 3, 1'b0, 48);
      add_pkt(1, 1, 1'b0, 64);
      add_pkt(3, 3, 1'b0, 48);
      add_pkt(4, 1, 1'b0, 64);
      for (int c = 0; c < 10; c++) begin
         if (c == 1) chk("grant after reset", DW'(grant_all), DW'(6'b001001));
         if (c == 2) chk("first beat after reset", m_data_all[DW-1:0], DW'(49));
         run_cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
